md_state_machine: RTL and testbench

- Hardware value-iteration engine for a Markov Decision Process on a grid world of up to 32 cells.
- Takes a packed 2-bit-per-cell world map, grid dimensions and FP16 (IEEE half) noise and discount parameters.
- Runs a programmed number of Bellman iterations and returns packed per-cell utilities and the optimal policy.
- Sits behind a host/controller using a start / done / ack handshake.

---
 rtl/md_state_machine.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_md_state_machine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/md_state_machine.sv
// -----------------------------------------------------------------------------
// md_state_machine
//
// Value-iteration engine for a Markov Decision Process on a grid world of up
// to MAX_CELLS cells. The host loads a packed world map, the grid dimensions
// and three FP16 parameters, then pulses start. The engine runs the requested
// number of Jacobi Bellman sweeps. It then presents per-cell utilities and the
// greedy policy, holding them until the host acknowledges.
//
// Optional feature macro: LIVING_REWARD_EN
//   defined   : each evaluated cell gets new[i] = gamma*best + (-0.04)
//   undefined : new[i] = gamma*best (no reward adder)
//
// Ports
//   clk           in   system clock, rising edge
//   Reset         in   synchronous active-low reset
//   start         in   begin a run (sampled in Init)
//   cont          in   run another batch from current utilities (sampled in Done)
//   ack           in   host accepts result, return to Init (sampled in Done)
//   iteration_in  in   [7:0]  sweeps per run
//   in_noise      in   [15:0] FP16 probability of the intended move
//   in_inv_noise  in   [15:0] FP16 probability of each perpendicular slip
//   in_discount   in   [15:0] FP16 discount gamma
//   in_world      in   [2*MAX_CELLS-1:0] 00 empty, 01 +terminal, 10 -terminal, 11 wall
//   in_depth      in   [7:0]  rows
//   in_width      in   [7:0]  columns
//   MDP_done      out  result valid
//   cur_util      out  [16*MAX_CELLS-1:0] FP16 utility of cell i at [16i+15:16i]
//   policy        out  [2*MAX_CELLS-1:0]  action of cell i: 00 U, 01 D, 10 L, 11 R
//   state         out  [12:0] one-hot FSM state
// -----------------------------------------------------------------------------
module md_state_machine #(
  parameter int MAX_CELLS = 32
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     start,
  input  logic                     cont,
  input  logic                     ack,
  input  logic [7:0]               iteration_in,
  input  logic [15:0]              in_noise,
  input  logic [15:0]              in_inv_noise,
  input  logic [15:0]              in_discount,
  input  logic [2*MAX_CELLS-1:0]   in_world,
  input  logic [7:0]               in_depth,
  input  logic [7:0]               in_width,
  output logic                     MDP_done,
  output logic [16*MAX_CELLS-1:0]  cur_util,
  output logic [2*MAX_CELLS-1:0]   policy,
  output logic [12:0]              state
);

  localparam int CW = $clog2(MAX_CELLS);  // cell index width

  localparam logic [1:0]  C_POS = 2'b01;
  localparam logic [1:0]  C_NEG = 2'b10;
  localparam logic [1:0]  C_WALL = 2'b11;
  localparam logic [15:0] FP_ONE = 16'h3C00;
  localparam logic [15:0] FP_MINUS_ONE = 16'hBC00;
`ifdef LIVING_REWARD_EN
  localparam logic [15:0] FP_LIVING_REWARD = 16'hA91F;  // -0.04
`endif

  typedef enum logic [12:0] {
    S_INIT     = 13'h0001,
    S_UP       = 13'h0002,
    S_DOWN     = 13'h0004,
    S_LEFT     = 13'h0008,
    S_RIGHT    = 13'h0010,
    S_UPDATE   = 13'h0020,
    S_DONE     = 13'h0040,
    S_CHECK    = 13'h0080,
    S_FIRST_M  = 13'h0100,
    S_MULTI    = 13'h0200,
    S_ADD      = 13'h0400,
    S_CONTINUE = 13'h0800,
    S_WORLD    = 13'h1000
  } state_t;

  typedef enum logic [1:0] {
    ACT_UP    = 2'b00,
    ACT_DOWN  = 2'b01,
    ACT_LEFT  = 2'b10,
    ACT_RIGHT = 2'b11
  } act_t;

  // ---------------------------------------------------------------------------
  // FP16 helpers: truncating, subnormals flushed to +0, overflow saturates.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] prod;
    logic [9:0]  m;
    logic        s;
    int          e;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return 16'h0000;
    prod = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (prod[21]) begin
      m = 10'(prod >> 11);
      e = e + 1;
    end else begin
      m = 10'(prod >> 10);
    end
    if (e <= 0) return 16'h0000;
    if (e >= 31) return {s, 15'h7BFF};
    return {s, 5'(e), m};
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] aa, bb, x, y;
    logic [24:0] mx, my_full, my, sum, norm;
    logic        sticky;
    int          d, pos, e;
    aa = (a[14:10] == 5'd0) ? 16'h0000 : a;
    bb = (b[14:10] == 5'd0) ? 16'h0000 : b;
    if (aa == 16'h0000) return bb;
    if (bb == 16'h0000) return aa;
    if (aa[14:0] >= bb[14:0]) begin
      x = aa;
      y = bb;
    end else begin
      x = bb;
      y = aa;
    end
    // Layout: [24] carry, [23] hidden one, [22:13] fraction, [12:0] guard.
    mx      = {1'b0, 1'b1, x[9:0], 13'b0};
    my_full = {1'b0, 1'b1, y[9:0], 13'b0};
    d = int'(x[14:10]) - int'(y[14:10]);
    if (d > 24) begin
      my     = '0;
      sticky = 1'b1;
    end else begin
      my     = my_full >> d;
      sticky = ((my << d) != my_full);
    end
    // When subtracting, bits lost off the aligned operand make the exact result
    // slightly smaller than mx-my; taking one more LSB keeps truncation exact.
    if (x[15] == y[15]) sum = mx + my;
    else                sum = mx - my - {24'b0, sticky};
    if (sum == '0) return 16'h0000;
    pos = 0;
    for (int k = 0; k < 25; k++) if (sum[k]) pos = k;
    e = int'(x[14:10]) + pos - 23;
    if (pos >= 23) norm = sum >> (pos - 23);
    else           norm = sum << (23 - pos);
    if (e <= 0) return 16'h0000;
    if (e >= 31) return {x[15], 15'h7BFF};
    return {x[15], 5'(e), 10'(norm >> 13)};
  endfunction

  // Strict a > b on FP16 values (no NaN/Inf).
  function automatic logic fp_gt(input logic [15:0] a, input logic [15:0] b);
    logic sa, sb;
    sa = a[15] && (a[14:0] != 15'd0);
    sb = b[15] && (b[14:0] != 15'd0);
    if (sa != sb) return sb;
    if (!sa) return a[14:0] > b[14:0];
    return a[14:0] < b[14:0];
  endfunction

  // First empty (non-terminal, non-wall) cell with index in [from, n), or -1.
  function automatic int first_active(input logic [MAX_CELLS-1:0][1:0] w,
                                      input int n, input int from);
    int r;
    r = -1;
    for (int k = 0; k < MAX_CELLS; k++)
      if (r < 0 && k >= from && k < n && w[k] == 2'b00) r = k;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                       state_q, state_d;
  logic [MAX_CELLS-1:0][1:0]    world_q, world_d;
  logic [7:0]                   width_q, width_d;
  logic [CW:0]                  n_q, n_d;
  logic [15:0]                  noise_q, noise_d, inv_q, inv_d, gamma_q, gamma_d;
  logic [7:0]                   iter_max_q, iter_max_d, iter_q, iter_d;
  logic [MAX_CELLS-1:0][15:0]   util_q, util_d, new_q, new_d;
  logic [MAX_CELLS-1:0][1:0]    pol_q, pol_d, pol_new_q, pol_new_d;
  logic [CW-1:0]                idx_q, idx_d;
  logic [CW-1:0]                i_int_q, i_int_d, i_p1_q, i_p1_d, i_p2_q, i_p2_d;
  act_t                         act_q, act_d, bestact_q, bestact_d;
  logic [15:0]                  p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
  logic [15:0]                  q_q, q_d, best_q, best_d;

  logic [MAX_CELLS-1:0][1:0]    world_in;
  assign world_in = in_world;

  // ---------------------------------------------------------------------------
  // Column of every cell, built by counting modulo width (avoids a divider).
  // ---------------------------------------------------------------------------
  logic [7:0] col_tab [MAX_CELLS];

  always_comb begin : col_gen
    int c;
    c = 0;
    for (int k = 0; k < MAX_CELLS; k++) begin
      col_tab[k] = 8'(c);
      if (c + 1 >= int'(width_q)) c = 0;
      else                        c = c + 1;
    end
  end

  // Move targets from the current cell; off-grid or wall keeps the agent put.
  logic [CW-1:0] nb_up, nb_dn, nb_lf, nb_rt;

  always_comb begin : nb_gen
    int i, w, n, col, t;
    i   = int'(idx_q);
    w   = int'(width_q);
    n   = int'(n_q);
    col = int'(col_tab[idx_q]);
    t = (i >= w) ? i - w : i;
    if (world_q[CW'(t)] == C_WALL) t = i;
    nb_up = CW'(t);
    t = (i + w < n) ? i + w : i;
    if (world_q[CW'(t)] == C_WALL) t = i;
    nb_dn = CW'(t);
    t = (col != 0) ? i - 1 : i;
    if (world_q[CW'(t)] == C_WALL) t = i;
    nb_lf = CW'(t);
    t = (col + 1 < w && i + 1 < n) ? i + 1 : i;
    if (world_q[CW'(t)] == C_WALL) t = i;
    nb_rt = CW'(t);
  end

  // Best-so-far selection; Up always seeds it so earlier actions win ties.
  logic        take_q;
  logic [15:0] best_sel, g_best, new_val;
  act_t        act_sel;

  assign take_q   = (act_q == ACT_UP) || fp_gt(q_q, best_q);
  assign best_sel = take_q ? q_q : best_q;
  assign act_sel  = take_q ? act_q : bestact_q;
  assign g_best   = fp_mul(gamma_q, best_sel);
`ifdef LIVING_REWARD_EN
  assign new_val  = fp_add(g_best, FP_LIVING_REWARD);
`else
  assign new_val  = g_best;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin : fsm_comb
    int n_in, fa;
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    world_d    = world_q;
    width_d    = width_q;
    n_d        = n_q;
    noise_d    = noise_q;
    inv_d      = inv_q;
    gamma_d    = gamma_q;
    iter_max_d = iter_max_q;
    iter_d     = iter_q;
    util_d     = util_q;
    new_d      = new_q;
    pol_d      = pol_q;
    pol_new_d  = pol_new_q;
    idx_d      = idx_q;
    i_int_d    = i_int_q;
    i_p1_d     = i_p1_q;
    i_p2_d     = i_p2_q;
    act_d      = act_q;
    bestact_d  = bestact_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    q_d        = q_q;
    best_d     = best_q;
    n_in       = int'(in_width) * int'(in_depth);
    if (n_in > MAX_CELLS) n_in = MAX_CELLS;
    fa         = -1;

    case (state_q)
      S_INIT: if (start) state_d = S_WORLD;

      S_WORLD: begin
        world_d    = world_in;
        width_d    = in_width;
        n_d        = (CW + 1)'(n_in);
        noise_d    = in_noise;
        inv_d      = in_inv_noise;
        gamma_d    = in_discount;
        iter_max_d = iteration_in;
        iter_d     = 8'd0;
        idx_d      = '0;
        pol_d      = '0;
        pol_new_d  = '0;
        for (int k = 0; k < MAX_CELLS; k++) begin
          util_d[k] = 16'h0000;
          if (k < n_in) begin
            if (world_in[k] == C_POS)      util_d[k] = FP_ONE;
            else if (world_in[k] == C_NEG) util_d[k] = FP_MINUS_ONE;
          end
        end
        // Skipped cells never get written again, so seed the sweep buffer too.
        new_d = util_d;
        if (iteration_in == 8'd0) begin
          state_d = S_DONE;
        end else begin
          fa = first_active(world_in, n_in, 0);
          if (fa >= 0) begin
            idx_d   = CW'(fa);
            state_d = S_UP;
          end else begin
            state_d = S_UPDATE;
          end
        end
      end

      S_UP: begin
        act_d = ACT_UP;    i_int_d = nb_up; i_p1_d = nb_lf; i_p2_d = nb_rt;
        state_d = S_FIRST_M;
      end
      S_DOWN: begin
        act_d = ACT_DOWN;  i_int_d = nb_dn; i_p1_d = nb_lf; i_p2_d = nb_rt;
        state_d = S_FIRST_M;
      end
      S_LEFT: begin
        act_d = ACT_LEFT;  i_int_d = nb_lf; i_p1_d = nb_up; i_p2_d = nb_dn;
        state_d = S_FIRST_M;
      end
      S_RIGHT: begin
        act_d = ACT_RIGHT; i_int_d = nb_rt; i_p1_d = nb_up; i_p2_d = nb_dn;
        state_d = S_FIRST_M;
      end

      S_FIRST_M: begin
        p0_d    = fp_mul(noise_q, util_q[i_int_q]);
        state_d = S_MULTI;
      end

      S_MULTI: begin
        p1_d    = fp_mul(inv_q, util_q[i_p1_q]);
        p2_d    = fp_mul(inv_q, util_q[i_p2_q]);
        state_d = S_ADD;
      end

      S_ADD: begin
        q_d     = fp_add(fp_add(p0_q, p1_q), p2_q);
        state_d = S_CHECK;
      end

      S_CHECK: begin
        best_d    = best_sel;
        bestact_d = act_sel;
        case (act_q)
          ACT_UP:   state_d = S_DOWN;
          ACT_DOWN: state_d = S_LEFT;
          ACT_LEFT: state_d = S_RIGHT;
          default: begin
            new_d[idx_q]     = new_val;
            pol_new_d[idx_q] = act_sel;
            fa = first_active(world_q, int'(n_q), int'(idx_q) + 1);
            if (fa >= 0) begin
              idx_d   = CW'(fa);
              state_d = S_UP;
            end else begin
              state_d = S_UPDATE;
            end
          end
        endcase
      end

      S_UPDATE: begin
        util_d = new_q;
        pol_d  = pol_new_q;
        iter_d = iter_q + 8'd1;
        if (iter_q + 8'd1 == iter_max_q) begin
          state_d = S_DONE;
        end else begin
          fa = first_active(world_q, int'(n_q), 0);
          if (fa >= 0) begin
            idx_d   = CW'(fa);
            state_d = S_UP;
          end else begin
            state_d = S_UPDATE;
          end
        end
      end

      S_DONE: begin
        if (ack)       state_d = S_INIT;
        else if (cont) state_d = S_CONTINUE;
      end

      S_CONTINUE: begin
        iter_d     = 8'd0;
        iter_max_d = iteration_in;
        if (iteration_in == 8'd0) begin
          state_d = S_DONE;
        end else begin
          fa = first_active(world_q, int'(n_q), 0);
          if (fa >= 0) begin
            idx_d   = CW'(fa);
            state_d = S_UP;
          end else begin
            state_d = S_UPDATE;
          end
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q    <= S_INIT;
      world_q    <= '0;
      width_q    <= '0;
      n_q        <= '0;
      noise_q    <= '0;
      inv_q      <= '0;
      gamma_q    <= '0;
      iter_max_q <= '0;
      iter_q     <= '0;
      // NOTE: the utility/policy arrays are flop banks driven straight onto the
      // host ports, so they are cleared on reset rather than left unknown.
      util_q     <= '0;
      new_q      <= '0;
      pol_q      <= '0;
      pol_new_q  <= '0;
      idx_q      <= '0;
      i_int_q    <= '0;
      i_p1_q     <= '0;
      i_p2_q     <= '0;
      act_q      <= ACT_UP;
      bestact_q  <= ACT_UP;
      p0_q       <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      q_q        <= '0;
      best_q     <= '0;
    end else begin
      state_q    <= state_d;
      world_q    <= world_d;
      width_q    <= width_d;
      n_q        <= n_d;
      noise_q    <= noise_d;
      inv_q      <= inv_d;
      gamma_q    <= gamma_d;
      iter_max_q <= iter_max_d;
      iter_q     <= iter_d;
      util_q     <= util_d;
      new_q      <= new_d;
      pol_q      <= pol_d;
      pol_new_q  <= pol_new_d;
      idx_q      <= idx_d;
      i_int_q    <= i_int_d;
      i_p1_q     <= i_p1_d;
      i_p2_q     <= i_p2_d;
      act_q      <= act_d;
      bestact_q  <= bestact_d;
      p0_q       <= p0_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      q_q        <= q_d;
      best_q     <= best_d;
    end
  end

  assign cur_util = util_q;
  assign policy   = pol_q;
  assign state    = state_q;
  assign MDP_done = (state_q == S_DONE);

endmodule

// File: tb/tb_md_state_machine.sv
// -----------------------------------------------------------------------------
// tb_md_state_machine
//
// Directed bench for md_state_machine on the 3x4 grid world:
//   row 0:  0  1  2  3(+1)
//   row 1:  4  5#  6  7(-1)
//   row 2:  8(-1)  9 10 11
// Expected values are hand-computed constants and relations.
// -----------------------------------------------------------------------------
module tb_md_state_machine;

  localparam logic [63:0] WORLD_A = 64'h0000_0000_0002_8C40;  // 3=01, 5=11, 7=10, 8=10
  localparam logic [63:0] WORLD_B = 64'h0000_0000_0002_CC40;  // cell 7 turned into a wall
  localparam int          BUDGET  = 5000;

  logic         clk = 1'b0;
  logic         Reset, start, cont, ack;
  logic [7:0]   iteration_in, in_depth, in_width;
  logic [15:0]  in_noise, in_inv_noise, in_discount;
  logic [63:0]  in_world;
  logic         MDP_done;
  logic [511:0] cur_util;
  logic [63:0]  policy;
  logic [12:0]  state;

  int checks   = 0;
  int failures = 0;

  logic [511:0] exp_init;
  logic [511:0] util10;
  logic [63:0]  pol10;

  always #5 clk = ~clk;

  md_state_machine #(.MAX_CELLS(32)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .start        (start),
    .cont         (cont),
    .ack          (ack),
    .iteration_in (iteration_in),
    .in_noise     (in_noise),
    .in_inv_noise (in_inv_noise),
    .in_discount  (in_discount),
    .in_world     (in_world),
    .in_depth     (in_depth),
    .in_width     (in_width),
    .MDP_done     (MDP_done),
    .cur_util     (cur_util),
    .policy       (policy),
    .state        (state)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] u(input int k);
    return cur_util[16*k +: 16];
  endfunction

  function automatic logic [1:0] pol(input int k);
    return policy[2*k +: 2];
  endfunction

  function automatic logic near(input logic [15:0] v, input logic [15:0] ref_v, input int tol);
    int diff;
    diff = int'(v) - int'(ref_v);
    return (diff <= tol) && (diff >= -tol);
  endfunction

  task automatic start_run(input logic [7:0] iters, input logic [63:0] world);
    @(negedge clk);
    iteration_in = iters;
    in_world     = world;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!MDP_done && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(tag, MDP_done, 1'b1);
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({tag, "_state"}, state, 13'h0001);
    check({tag, "_done"}, MDP_done, 1'b0);
  endtask

  initial begin
    Reset        = 1'b0;
    start        = 1'b0;
    cont         = 1'b0;
    ack          = 1'b0;
    iteration_in = 8'd0;
    in_noise     = 16'h3A66;
    in_inv_noise = 16'h2E66;
    in_discount  = 16'h3B33;
    in_world     = WORLD_A;
    in_depth     = 8'd3;
    in_width     = 8'd4;

    exp_init = '0;
    exp_init[16*3 +: 16] = 16'h3C00;
    exp_init[16*7 +: 16] = 16'hBC00;
    exp_init[16*8 +: 16] = 16'hBC00;

    // Reset
    repeat (5) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    check("rst_state", state, 13'h0001);
    check("rst_done", MDP_done, 1'b0);
    check("rst_util", cur_util, '0);
    check("rst_policy", policy, '0);

    // Zero iterations: world_builder, then Done on the following edge
    start_run(8'd0, WORLD_A);
    check("it0_world_builder", state, 13'h1000);
    @(negedge clk);
    check("it0_state_done", state, 13'h0040);
    check("it0_done", MDP_done, 1'b1);
    check("it0_util", cur_util, exp_init);
    check("it0_policy", policy, '0);
    do_ack("it0_ack");

    // Reset in the middle of a run aborts it
    start_run(8'd3, WORLD_A);
    repeat (30) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    Reset = 1'b1;
    check("midrst_state", state, 13'h0001);
    check("midrst_util", cur_util, '0);

    // One sweep
    start_run(8'd1, WORLD_A);
    wait_done("it1_timeout");
    check("it1_c2_util_near_39c2", near(u(2), 16'h39C2, 2), 1'b1);
    check("it1_c2_policy", pol(2), 2'b11);
    check("it1_c3_util", u(3), 16'h3C00);
    check("it1_c7_util", u(7), 16'hBC00);
    check("it1_c5_util", u(5), 16'h0000);
    check("it1_c0_util", u(0), 16'h0000);
    check("it1_c1_util", u(1), 16'h0000);
    check("it1_c0_policy", pol(0), 2'b00);
    check("it1_c1_policy", pol(1), 2'b00);
    check("it1_c6_policy_left", pol(6), 2'b10);
    check("it1_unused_cells", cur_util[511:192], '0);
    do_ack("it1_ack");

    // Ten sweeps
    start_run(8'd10, WORLD_A);
    wait_done("it10_timeout");
    check("it10_c2_policy", pol(2), 2'b11);
    check("it10_c6_policy", pol(6), 2'b00);
    check("it10_c0_positive", (u(0)[15] == 1'b0) && (u(0) != 16'h0000), 1'b1);
    check("it10_c1_gt_c0", (u(1)[15] == 1'b0) && (u(1) > u(0)), 1'b1);
    check("it10_c2_gt_c1", (u(2)[15] == 1'b0) && (u(2) > u(1)), 1'b1);
    check("it10_c8_util", u(8), 16'hBC00);
    util10 = cur_util;
    pol10  = policy;
    repeat (20) @(negedge clk);
    check("it10_done_held", MDP_done, 1'b1);
    check("it10_util_stable", cur_util, util10);
    check("it10_policy_stable", policy, pol10);
    do_ack("it10_ack");

    // Five sweeps, continue for five more: must equal the ten-sweep run
    start_run(8'd5, WORLD_A);
    wait_done("cont_first_timeout");
    @(negedge clk);
    cont = 1'b1;
    @(negedge clk);
    cont = 1'b0;
    check("cont_state", state, 13'h0800);
    wait_done("cont_second_timeout");
    check("cont_util_eq_10", cur_util, util10);
    check("cont_policy_eq_10", policy, pol10);
    // ack wins over cont
    @(negedge clk);
    ack  = 1'b1;
    cont = 1'b1;
    @(negedge clk);
    ack  = 1'b0;
    cont = 1'b0;
    check("ack_priority_state", state, 13'h0001);
    check("ack_priority_done", MDP_done, 1'b0);

    // Fresh run with cell 7 turned into a wall
    start_run(8'd1, WORLD_B);
    wait_done("wall_timeout");
    check("wall_c7_util", u(7), 16'h0000);
    check("wall_c7_policy", pol(7), 2'b00);
    check("wall_c8_util", u(8), 16'hBC00);
    check("wall_c2_util_near_39c2", near(u(2), 16'h39C2, 2), 1'b1);
    check("wall_c6_policy", pol(6), 2'b00);
    do_ack("wall_ack");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
